// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding and word stride.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  localparam logic [31:0] WORD_STRIDE = 32'd4;

endpackage

// File: rtl/imem_checksum.sv
// 32-bit wrapping accumulator with synchronous clear and enable; sums program words.
module imem_checksum (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [31:0] i_data,
  output logic [31:0] o_sum
);

  logic [31:0] r_sum;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_sum <= 32'd0;
    end else if (i_en) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/imem_loader.sv
// Streams program words into instruction memory and releases the pipeline when complete.
// Optional trailing checksum word is enabled with IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH     = 128,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_data,
  input  logic                   in_last,
  output logic                   mem_we,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  output logic [$clog2(DEPTH):0] word_count,
  output logic                   busy,
  output logic                   run,
  output logic                   err
);

  localparam int            CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

  state_t        r_state;
  state_t        w_next;
  logic [31:0]   r_ptr;
  logic [CW-1:0] r_count;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_run;
  logic          r_err;
  logic          w_restart;
  logic          w_load_beat;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] w_sum;

  imem_checksum u_checksum (
    .i_clk  (Clk),
    .i_rst  (Rst),
    .i_clr  (w_restart),
    .i_en   (w_load_beat),
    .i_data (in_data),
    .o_sum  (w_sum)
  );
`endif

  // Handshake decoded from registered state only: no path from in_valid to in_ready.
  assign in_ready = (r_state == LOAD) || (r_state == CHECK);
  assign busy     = in_ready;

  always_comb begin
    w_next      = r_state;
    w_restart   = 1'b0;
    w_load_beat = 1'b0;
    case (r_state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          w_next    = LOAD;
          w_restart = 1'b1;
        end
      end
      LOAD: begin
        if (in_valid) begin
          w_load_beat = 1'b1;
          if (in_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            w_next = CHECK;
`else
            w_next = DONE;
`endif
          end else if (r_count == LAST_IDX) begin
            w_next = ERROR;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (in_valid) begin
          w_next = (in_data == w_sum) ? DONE : ERROR;
        end
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= IDLE;
      r_ptr   <= BASE_ADDR;
      r_count <= '0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_run   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_we    <= w_load_beat;
      if (w_restart) begin
        r_ptr   <= BASE_ADDR;
        r_count <= '0;
      end else if (w_load_beat) begin
        r_addr  <= r_ptr;
        r_wdata <= in_data;
        r_ptr   <= r_ptr + WORD_STRIDE;
        r_count <= r_count + 1'b1;
      end
      // run lags DONE entry by a cycle so the final write strobe completes first.
      r_run <= (r_state == DONE) && (w_next == DONE);
      r_err <= (w_next == ERROR);
    end
  end

  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign word_count = r_count;
  assign run        = r_run;
  assign err        = r_err;

endmodule
